// File: rtl/model_loader_pkg.sv
// Shared constants and FSM state type for the model-loader DDR/SD movers.
package model_loader_pkg;
  localparam int SECTOR_BYTES     = 512;
  localparam int SD_WORD_W        = 16;
  localparam int SD_WORDS_PER_SEC = 256;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_RD,
    ST_WAIT_IDLE,
    ST_DATA,
    ST_DRAIN,
    ST_FIN
  } wr_state_e;
endpackage

// File: rtl/sd_sector_buf.sv
// One-sector staging buffer: AXI beats go in whole, 16-bit SD words come out
// LSB-first through a registered read port that holds between reads.
module sd_sector_buf
  import model_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  localparam int BEATS  = (SECTOR_BYTES * 8) / DATA_WIDTH,
  localparam int WPB    = DATA_WIDTH / SD_WORD_W,
  localparam int BEAT_W = $clog2(BEATS),
  localparam int WSEL_W = $clog2(WPB)
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [BEAT_W-1:0]     wr_beat,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [7:0]            rd_word,
  output logic [15:0]           rd_data
);
  logic [DATA_WIDTH-1:0] mem [BEATS];

  // beat write port
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_beat] <= wr_data;
  end

  // word read port; rd_zero returns 0 for requests outside the sector window
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= rd_zero ? 16'h0000 :
                               mem[rd_word[7:WSEL_W]][{rd_word[WSEL_W-1:0], 4'b0000} +: 16];
  end
endmodule

// File: rtl/ddr_sd_write_para.sv
// DDR -> SD sector writer: one AXI4 INCR burst per 512-byte sector, then the
// sector is streamed to the SD controller write port word by word.
// Optional macro SD_WR_RRESP_CHECK_EN: non-OKAY rresp raises sticky error and
// the job ends after the current burst without writing that sector.
module ddr_sd_write_para
  import model_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [16:0]           sd_sec_num,
  input  logic [31:0]           sd_addr_base,
  input  logic [ADDR_WIDTH-1:0] ddr_addr_base,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ID_WIDTH-1:0]   model_arid,
  output logic [ADDR_WIDTH-1:0] model_araddr,
  output logic [7:0]            model_arlen,
  output logic [2:0]            model_arsize,
  output logic [1:0]            model_arburst,
  output logic                  model_arlock,
  output logic [3:0]            model_arcache,
  output logic [2:0]            model_arprot,
  output logic                  model_arvalid,
  input  logic                  model_arready,
  input  logic [ID_WIDTH-1:0]   model_rid,
  input  logic [DATA_WIDTH-1:0] model_rdata,
  input  logic [1:0]            model_rresp,
  input  logic                  model_rlast,
  input  logic                  model_rvalid,
  output logic                  model_rready,
  output logic                  sd_wr_start_en,
  output logic [31:0]           sd_wr_sec_addr,
  input  logic                  sd_wr_busy,
  input  logic                  sd_wr_req,
  output logic [15:0]           sd_wr_data
);
  localparam int BEATS  = (SECTOR_BYTES * 8) / DATA_WIDTH;
  localparam int BEAT_W = $clog2(BEATS);

  wr_state_e             state, nxt;
  logic [16:0]           sec_num_q, k, k_inc, wptr;
  logic [31:0]           sd_base_q;
  logic [ADDR_WIDTH-1:0] ddr_base_q;
  logic [BEAT_W-1:0]     beat;
  logic                  burst_err, beat_err, rd_hs, unused_in;

  assign k_inc = k + 17'd1;
  assign rd_hs = (state == ST_RD) && model_rvalid;

  assign busy          = (state != ST_IDLE);
  assign model_arvalid = (state == ST_AR);
  assign model_rready  = (state == ST_RD);
  assign model_araddr  = ddr_base_q + ADDR_WIDTH'({k, 9'd0});
  assign model_arid    = '0;
  assign model_arlen   = 8'(BEATS - 1);
  assign model_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign model_arburst = AXI_BURST_INCR;
  assign model_arlock  = 1'b0;
  assign model_arcache = AXI_CACHE_DEFAULT;
  assign model_arprot  = 3'b000;

`ifdef SD_WR_RRESP_CHECK_EN
  logic err_q;
  assign beat_err  = (model_rresp != 2'b00);
  assign error     = err_q;
  assign unused_in = ^{model_rid, wptr[16:8], ddr_addr_base[8:0]};

  // sticky error, cleared by an accepted start
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                             err_q <= 1'b0;
    else if (state == ST_IDLE && start)  err_q <= 1'b0;
    else if (rd_hs && beat_err)          err_q <= 1'b1;
  end
`else
  assign beat_err  = 1'b0;
  assign error     = 1'b0;
  assign unused_in = ^{model_rid, model_rresp, wptr[16:8], ddr_addr_base[8:0]};
`endif

  // state register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:      if (start) nxt = (sd_sec_num == 17'd0) ? ST_FIN : ST_AR;
      ST_AR:        if (model_arready) nxt = ST_RD;
      ST_RD:        if (rd_hs && model_rlast)
                      nxt = (burst_err || beat_err) ? ST_FIN : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (!sd_wr_busy) nxt = ST_DATA;
      ST_DATA:      if (sd_wr_req && wptr == 17'd255) nxt = ST_DRAIN;
      ST_DRAIN:     if (!sd_wr_busy) nxt = (k_inc == sec_num_q) ? ST_FIN : ST_AR;
      ST_FIN:       nxt = ST_IDLE;
      default:      nxt = ST_IDLE;
    endcase
  end

  // job registers, counters, SD handshake outputs
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sec_num_q      <= '0;
      sd_base_q      <= '0;
      ddr_base_q     <= '0;
      k              <= '0;
      beat           <= '0;
      wptr           <= '0;
      burst_err      <= 1'b0;
      done           <= 1'b0;
      sd_wr_start_en <= 1'b0;
      sd_wr_sec_addr <= '0;
    end else begin
      sd_wr_start_en <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          sec_num_q  <= sd_sec_num;
          sd_base_q  <= sd_addr_base;
          ddr_base_q <= {ddr_addr_base[ADDR_WIDTH-1:9], 9'd0};
          k          <= '0;
          burst_err  <= 1'b0;
          done       <= 1'b0;
        end
        ST_AR: beat <= '0;
        ST_RD: if (rd_hs) begin
          beat <= beat + 1'b1;
          if (beat_err) burst_err <= 1'b1;
        end
        ST_WAIT_IDLE: if (!sd_wr_busy) begin
          sd_wr_start_en <= 1'b1;
          sd_wr_sec_addr <= sd_base_q + 32'(k);
          wptr           <= '0;
        end
        ST_DATA:  if (sd_wr_req) wptr <= wptr + 17'd1;
        ST_DRAIN: if (!sd_wr_busy) k <= k_inc;
        ST_FIN:   done <= 1'b1;
        default:  ;
      endcase
    end
  end

  sd_sector_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .sys_clk (sys_clk),
    .rst     (rst),
    .wr_en   (rd_hs),
    .wr_beat (beat),
    .wr_data (model_rdata),
    .rd_en   (sd_wr_req),
    .rd_zero (state != ST_DATA),
    .rd_word (wptr[7:0]),
    .rd_data (sd_wr_data)
  );
endmodule

// File: doc/ddr_sd_write_para.md
# ddr_sd_write_para

Model-loader companion that moves data the opposite way to the SD-read path: it fetches sectors from DDR as an AXI4 read master and feeds them, one 512-byte sector at a time, to the SD card controller's user write port. It sits beside the SD-read block in the model loader. Software programs the sector count and base addresses, pulses `start`, and polls `done` or `error`.

## Interface
Parameters:
- `DATA_WIDTH`, 256: AXI data width. Power of two, 32..512.
- `ADDR_WIDTH`, 32: AXI address width.
- `ID_WIDTH`, 8: AXI ID width.

Ports (one clock; reset is asynchronous and active-high):
- `sys_clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  one-cycle pulse that launches a job. Ignored while `busy`.
- `sd_sec_num`  in  17  number of sectors to write. Sampled at `start`.
- `sd_addr_base`  in  32  first SD sector address. Sampled at `start`.
- `ddr_addr_base`  in  ADDR_WIDTH  DDR byte address. Sampled at `start`; bits [8:0] are forced to 0.
- `busy`  out  1  high while a job is active.
- `done`  out  1  sticky; set at job end, cleared by `start`.
- `error`  out  1  sticky; cleared by `start` (see Configuration).
- `model_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid`  out  AXI AR channel.
- `model_arready`  in  1  AR ready.
- `model_rid/rdata/rresp/rlast/rvalid`  in  AXI R channel.
- `model_rready`  out  1  R ready.
- `sd_wr_start_en`  out  1  one-cycle pulse that starts a sector write.
- `sd_wr_sec_addr`  out  32  sector address. Held from the pulse until the sector completes.
- `sd_wr_busy`  in  1  SD controller busy.
- `sd_wr_req`  in  1  SD controller requests the next 16-bit word.
- `sd_wr_data`  out  16  word supplied in response to `sd_wr_req`.

## Operation
- Definitions: BEATS = 4096/DATA_WIDTH (16 at the default width); WPB = DATA_WIDTH/16 words per beat.
- Fixed AR fields: `arlen`=BEATS-1, `arsize`=log2(DATA_WIDTH/8), `arburst`=INCR, `arid`=0, `arlock`=0, `arcache`=4'b0011, `arprot`=0.
- A 512-byte-aligned burst never crosses a 4 KB boundary.
- FSM states:
  - IDLE: on `start`, latch inputs, clear `done` and `error`. If `sd_sec_num`=0, go to FIN; otherwise go to AR.
  - AR: assert `arvalid` with `araddr` = ddr_base + 512·k. Go to RD on `arready`.
  - RD: `rready`=1. Beat i is written into buffer slot i. On the beat with `rlast`, go to WAIT_IDLE.
  - WAIT_IDLE: when `sd_wr_busy`=0, pulse `sd_wr_start_en` with `sd_wr_sec_addr` = sd_base + k, then go to DATA.
  - DATA: each `sd_wr_req` advances the word pointer 0..255.
    - Word w = buffer[w/WPB] bits [16·(w%WPB)+15 : 16·(w%WPB)], LSB-first.
    - After word 255, go to DRAIN.
    - Any further requests return 16'h0000.
  - DRAIN: wait for `sd_wr_busy` to fall, then k++. If k = sec_num, go to FIN; otherwise go to AR.
  - FIN: set `done`, go to IDLE.
- `busy` = (state != IDLE).
- `start` while busy: no effect.
- The word pointer and sector counter k are 17 bits; the counter does not wrap.
- Address arithmetic is modulo 2^ADDR_WIDTH and 2^32 respectively.

## Timing
- Reset values:
  - all AXI valid/ready outputs = 0; `araddr` = 0.
  - `sd_wr_start_en` = 0, `sd_wr_sec_addr` = 0, `sd_wr_data` = 0.
  - `busy`, `done`, `error` = 0; state = IDLE.
- `start` → `arvalid` high on the next cycle.
- `arvalid` is held stable until `arready`.
- `sd_wr_data` is registered and valid the cycle after `sd_wr_req`. It holds its value until the next request.
- Back-to-back `sd_wr_req` on consecutive cycles is supported.
- Last beat → `sd_wr_start_en` no earlier than 1 cycle later.
- sec_num = 0: `done` is high 2 cycles after `start`.
- Asserting `rst` mid-job aborts immediately. No AXI completion is guaranteed; this is acceptable only on system reset.

## Configuration
- `SD_WR_RRESP_CHECK_EN` defined:
  - any beat with `rresp`!=0 sets `error`.
  - The remainder of the burst is still drained. The FSM then goes to FIN without starting the SD write.
  - `done` is also set.
- Not defined: `rresp` is ignored and `error` is tied to 0.

## Structure
- Package `model_loader_pkg` holds:
  - SECTOR_BYTES=512, SD_WORD_W=16, SD_WORDS_PER_SEC=256.
  - AXI_BURST_INCR, AXI_CACHE_DEFAULT.
  - the FSM state enum.
- Sub-module `sd_sector_buf`: BEATS×DATA_WIDTH storage with a beat-indexed write port and a 16-bit word-indexed registered read port.

## Test plan
- sec_num=1, sd_base=0x100, ddr_base=0x8000_0000:
  - one AR with araddr=0x8000_0000 and arlen=15, then a start pulse with sec_addr=0x100.
  - 256 words match the DDR pattern, LSB-first; `done`=1.
- sec_num=3 with a random `arready`/`rvalid` stall pattern and `sd_wr_req` gaps → three ARs at +0x000/+0x200/+0x400, sec_addr 0x100..0x102, 768 words correct.
- `start` with sec_num=0 → no AR, no SD pulse, `done` at cycle +2.
- Second `start` while busy → ignored; the job completes with its original parameters.
- With `SD_WR_RRESP_CHECK_EN`, `rresp`=2 on beat 5 → 16 beats accepted, no `sd_wr_start_en`, `error`=1, `done`=1.
- `rst` asserted during DATA → all outputs at reset values the same cycle; a new `start` runs cleanly.
